alu_seq_divider: RTL

- Multi-cycle 16-bit integer divider for the ALU. It is the inverse-direction counterpart of the saturating add/sub datapath: it computes quotient and remainder by repeated shift-and-subtract (restoring).
- Sits beside the combinational adder in the execute stage. The pipeline stalls on busy and captures results on done.
- Signed mode truncates toward zero. Signed mode saturates quotient overflow in the same way as the saturating adder (0x7FFF / 0x8000).

---
 rtl/alu_seq_divider.sv | 96 +++++++++
 1 files changed

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: multi-cycle restoring shift-subtract divider, signed mode truncates toward zero
// and saturates the single overflow case like the saturating adder.
module alu_seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Ovfl
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX = ~MIN;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] prem, dq, dvs, diff;
  logic [WIDTH:0]   shifted;
  logic             qneg, rneg, ge, ovf_case;
  // dq holds the shifting dividend and collects quotient bits from the LSB side
  always_comb begin
    shifted  = {prem, dq[WIDTH-1]};
    ge       = shifted >= {1'b0, dvs};
    diff     = shifted[WIDTH-1:0] - dvs;
    ovf_case = signed_op && Dividend == MIN && Divisor == '1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      prem      <= '0;
      dq        <= '0;
      dvs       <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
      Ovfl      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (Divisor == '0) begin
            Quotient  <= signed_op ? (Dividend[WIDTH-1] ? MIN : MAX) : '1;
            Remainder <= Dividend;
            DivZero   <= 1'b1;
            Ovfl      <= 1'b0;
            done      <= 1'b1;
          end else if (ovf_case) begin
            Quotient  <= MAX;
            Remainder <= '0;
            DivZero   <= 1'b0;
            Ovfl      <= 1'b1;
            done      <= 1'b1;
          end else begin
            dq      <= signed_op && Dividend[WIDTH-1] ? -Dividend : Dividend;
            dvs     <= signed_op && Divisor[WIDTH-1] ? -Divisor : Divisor;
            qneg    <= signed_op && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
            rneg    <= signed_op && Dividend[WIDTH-1];
            prem    <= '0;
            cnt     <= '0;
            DivZero <= 1'b0;
            Ovfl    <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          prem  <= ge ? diff : shifted[WIDTH-1:0];
          dq    <= {dq[WIDTH-2:0], ge};
          cnt   <= cnt + 1'b1;
          state <= cnt == CNT_W'(WIDTH-1) ? FIX : RUN;
        end
        FIX: begin
          Quotient  <= qneg ? -dq : dq;
          Remainder <= rneg ? -prem : prem;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
